queue_ctrl: RTL and testbench

- Sequencing controller placed between the deserializer byte output, the 8x8 queue, and the downstream byte consumer.
- Accepts bytes from the deserializer, issues single-cycle enqueue and dequeue commands to the queue, and presents dequeued bytes to the consumer on a valid/ready handshake.
- Arbitrates between pending enqueue and dequeue requests, because the queue accepts at most one operation per cycle.
- Keeps a shadow occupancy count and flags any disagreement with the queue's reported length.

---
 rtl/queue_ctrl.sv | 176 +++++++++++++++++
 tb/tb_queue_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_ctrl.sv
// ============================================================================
// queue_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller sitting between the deserializer byte output, the
// 8x8 byte queue and the downstream byte consumer.
//
// Enqueue and dequeue compete for the queue, which accepts at most one
// operation per cycle. When both are pending, the grant alternates. A shadow
// occupancy count is kept beside the queue and compared against the queue's
// own length whenever the controller is idle.
//
// Ports
//   clock           system clock
//   reset           synchronous, active-high reset
//   des_data_in     byte offered by the deserializer
//   des_valid_in    deserializer byte available (held until ack_out)
//   ack_out         one-cycle pulse: deserializer byte accepted
//   q_data_out      byte written into the queue
//   q_enq_out       queue enqueue command (single cycle)
//   q_deq_out       queue dequeue command (single cycle)
//   q_data_in       byte popped from the queue
//   q_len_in        queue's reported length
//   cons_data_out   byte presented to the consumer
//   cons_valid_out  cons_data_out holds a valid byte
//   cons_ready_in   consumer takes the byte
//   count_out       shadow occupancy, 0..DEPTH
//   full_out        count_out == DEPTH
//   empty_out       count_out == 0
//   len_err_out     sticky: queue length disagreed with count_out while idle
// ============================================================================
module queue_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] des_data_in,
    input  logic             des_valid_in,
    output logic             ack_out,
    output logic [WIDTH-1:0] q_data_out,
    output logic             q_enq_out,
    output logic             q_deq_out,
    input  logic [WIDTH-1:0] q_data_in,
    input  logic [LEN_W-1:0] q_len_in,
    output logic [WIDTH-1:0] cons_data_out,
    output logic             cons_valid_out,
    input  logic             cons_ready_in,
    output logic [LEN_W-1:0] count_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             len_err_out
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENQ,
        S_DEQ_REQ,
        S_DEQ_WAIT
    } state_t;

    state_t           r_state;
    logic             r_last_grant_enq;   // 1: most recent grant was an enqueue
    logic             r_ack;
    logic [WIDTH-1:0] r_q_data;
    logic             r_q_enq;
    logic             r_q_deq;
    logic [WIDTH-1:0] r_cons_data;
    logic             r_cons_valid;
    logic [LEN_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_len_err;

    logic             w_enq_req;
    logic             w_deq_req;
    logic             w_grant_enq;
    logic             w_grant_deq;

    // Request terms are only acted upon in IDLE.
    assign w_enq_req = des_valid_in && (r_count < DEPTH_L);
    // A dequeue needs a free output register: the popped byte lands there
    // two cycles later with no way to push back.
    assign w_deq_req = (r_count != '0) && !r_cons_valid;

    // On contention, grant whichever side did not win last time.
    assign w_grant_enq = w_enq_req && (!w_deq_req || !r_last_grant_enq);
    assign w_grant_deq = w_deq_req && (!w_enq_req ||  r_last_grant_enq);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_last_grant_enq <= 1'b0;
            r_ack            <= 1'b0;
            r_q_data         <= '0;
            r_q_enq          <= 1'b0;
            r_q_deq          <= 1'b0;
            r_cons_data      <= '0;
            r_cons_valid     <= 1'b0;
            r_count          <= '0;
            r_full           <= 1'b0;
            r_empty          <= 1'b1;
            r_len_err        <= 1'b0;
        end else begin
            // Consumer handshake runs independently of the FSM so that a
            // stalled consumer never blocks enqueues.
            if (r_cons_valid && cons_ready_in) begin
                r_cons_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (q_len_in != r_count) begin
                        r_len_err <= 1'b1;
                    end
                    if (w_grant_enq) begin
                        r_state          <= S_ENQ;
                        r_q_enq          <= 1'b1;
                        r_ack            <= 1'b1;
                        r_q_data         <= des_data_in;
                        r_last_grant_enq <= 1'b1;
                    end else if (w_grant_deq) begin
                        r_state          <= S_DEQ_REQ;
                        r_q_deq          <= 1'b1;
                        r_last_grant_enq <= 1'b0;
                    end
                end

                // The queue takes the byte on this closing edge, so the
                // shadow count moves in step with the queue's length.
                S_ENQ: begin
                    r_q_enq <= 1'b0;
                    r_ack   <= 1'b0;
                    r_count <= r_count + ONE_L;
                    r_full  <= (r_count == DEPTH_L - ONE_L);
                    r_empty <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_DEQ_REQ: begin
                    r_q_deq <= 1'b0;
                    r_count <= r_count - ONE_L;
                    r_full  <= 1'b0;
                    r_empty <= (r_count == ONE_L);
                    r_state <= S_DEQ_WAIT;
                end

                // The queue is driving the popped byte during this cycle.
                S_DEQ_WAIT: begin
                    r_cons_data  <= q_data_in;
                    r_cons_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_out        = r_ack;
    assign q_data_out     = r_q_data;
    assign q_enq_out      = r_q_enq;
    assign q_deq_out      = r_q_deq;
    assign cons_data_out  = r_cons_data;
    assign cons_valid_out = r_cons_valid;
    assign count_out      = r_count;
    assign full_out       = r_full;
    assign empty_out      = r_empty;
    assign len_err_out    = r_len_err;

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed bench for queue_ctrl with a behavioural 8-entry FIFO standing in
// for the queue and a scoreboard of accepted bytes checked at the consumer.
module tb_queue_ctrl;

    logic       clock;
    logic       reset;
    logic [7:0] des_data_in;
    logic       des_valid_in;
    logic       ack_out;
    logic [7:0] q_data_out;
    logic       q_enq_out;
    logic       q_deq_out;
    logic [7:0] q_data_in;
    logic [7:0] q_len_in;
    logic [7:0] cons_data_out;
    logic       cons_valid_out;
    logic       cons_ready_in;
    logic [7:0] count_out;
    logic       full_out;
    logic       empty_out;
    logic       len_err_out;

    queue_ctrl #(.WIDTH(8), .DEPTH(8), .LEN_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .des_data_in    (des_data_in),
        .des_valid_in   (des_valid_in),
        .ack_out        (ack_out),
        .q_data_out     (q_data_out),
        .q_enq_out      (q_enq_out),
        .q_deq_out      (q_deq_out),
        .q_data_in      (q_data_in),
        .q_len_in       (q_len_in),
        .cons_data_out  (cons_data_out),
        .cons_valid_out (cons_valid_out),
        .cons_ready_in  (cons_ready_in),
        .count_out      (count_out),
        .full_out       (full_out),
        .empty_out      (empty_out),
        .len_err_out    (len_err_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural FIFO queue model
    logic [7:0] qm[$];
    logic [7:0] qm_len;
    logic [7:0] qm_rd;
    logic       len_force;

    always @(posedge clock) begin
        if (reset) begin
            qm.delete();
            qm_len <= 8'd0;
            qm_rd  <= 8'd0;
        end else begin
            if (q_enq_out && qm.size() < 8) qm.push_back(q_data_out);
            if (q_deq_out && qm.size() > 0) qm_rd <= qm.pop_front();
            qm_len <= 8'(qm.size());
        end
    end

    assign q_data_in = qm_rd;
    assign q_len_in  = len_force ? 8'd5 : qm_len;

    // Scoreboard and bookkeeping
    logic [7:0] sb[$];
    int         pulse_log[$];
    int         n_chk, n_fail;
    int         n_ack, n_enq, n_deq, n_cons;
    logic       prev_enq, prev_deq;
    logic       sb_en;
    logic [7:0] stream_end;
    int         a0, e0, d0, c0, b, np;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: settle the consumer handshake that the coming edge
    // performs, then sample at the falling edge and feed the deserializer.
    task automatic tick();
        if (!reset && cons_valid_out && cons_ready_in) begin
            n_cons++;
            if (sb.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
            else chk("cons_data_order", 32'(cons_data_out), 32'(sb.pop_front()));
        end
        @(negedge clock);
        if (!reset) begin
            chk("enq_deq_overlap", 32'(q_enq_out & q_deq_out), 32'(0));
            chk("enq_repeat", 32'(q_enq_out & prev_enq), 32'(0));
            chk("deq_repeat", 32'(q_deq_out & prev_deq), 32'(0));
            chk("ack_with_enq", 32'(ack_out), 32'(q_enq_out));
            chk("full_flag", 32'(full_out), 32'(count_out == 8'd8));
            chk("empty_flag", 32'(empty_out), 32'(count_out == 8'd0));
        end
        prev_enq = q_enq_out;
        prev_deq = q_deq_out;
        if (q_enq_out) begin n_enq++; pulse_log.push_back(1); end
        if (q_deq_out) begin n_deq++; pulse_log.push_back(2); end
        if (ack_out && !reset) begin
            n_ack++;
            if (sb_en) sb.push_back(des_data_in);
            if (des_data_in == stream_end) des_valid_in = 1'b0;
            else des_data_in = 8'(des_data_in + 8'd1);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        n_ack = 0; n_enq = 0; n_deq = 0; n_cons = 0;
        prev_enq = 1'b0; prev_deq = 1'b0;
        reset = 1'b1; des_data_in = 8'd0; des_valid_in = 1'b0;
        cons_ready_in = 1'b0; len_force = 1'b0; sb_en = 1'b1; stream_end = 8'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_ack", 32'(ack_out), 32'(0));
        chk("rst_q_enq", 32'(q_enq_out), 32'(0));
        chk("rst_q_deq", 32'(q_deq_out), 32'(0));
        chk("rst_q_data", 32'(q_data_out), 32'(0));
        chk("rst_cons_valid", 32'(cons_valid_out), 32'(0));
        chk("rst_cons_data", 32'(cons_data_out), 32'(0));
        chk("rst_count", 32'(count_out), 32'(0));
        chk("rst_full", 32'(full_out), 32'(0));
        chk("rst_empty", 32'(empty_out), 32'(1));
        chk("rst_len_err", 32'(len_err_out), 32'(0));

        // Single byte 0xA5, consumer stalled
        reset = 1'b0;
        des_data_in = 8'hA5; stream_end = 8'hA5; des_valid_in = 1'b1;
        a0 = n_ack; e0 = n_enq; b = 0;
        while (n_enq == e0 && b < 10) begin tick(); b++; end
        chk("t1_enq_seen", 32'(n_enq - e0), 32'(1));
        chk("t1_q_data", 32'(q_data_out), 32'hA5);
        tick();
        chk("t1_count", 32'(count_out), 32'(1));
        chk("t1_empty", 32'(empty_out), 32'(0));
        chk("t1_qlen", 32'(q_len_in), 32'(1));
        d0 = n_deq; b = 0;
        while (n_deq == d0 && b < 10) begin tick(); b++; end
        chk("t3_deq_seen", 32'(n_deq - d0), 32'(1));
        tick();
        chk("t3_valid_lat1", 32'(cons_valid_out), 32'(0));
        chk("t3_count", 32'(count_out), 32'(0));
        tick();
        chk("t3_valid_lat2", 32'(cons_valid_out), 32'(1));
        chk("t3_cons_data", 32'(cons_data_out), 32'hA5);
        chk("t3_empty", 32'(empty_out), 32'(1));
        chk("t1_single_ack", 32'(n_ack - a0), 32'(1));
        chk("t1_single_enq", 32'(n_enq - e0), 32'(1));

        // Fill to full while the consumer stalls on 0xA5
        des_data_in = 8'h01; stream_end = 8'hFF; des_valid_in = 1'b1;
        a0 = n_ack; e0 = n_enq; d0 = n_deq; b = 0;
        while ((n_ack - a0) < 8 && b < 40) begin
            tick(); b++;
            chk("stall_data", 32'(cons_data_out), 32'hA5);
            chk("stall_valid", 32'(cons_valid_out), 32'(1));
        end
        repeat (20) begin
            tick();
            chk("stall_data", 32'(cons_data_out), 32'hA5);
            chk("stall_valid", 32'(cons_valid_out), 32'(1));
        end
        chk("full_acks", 32'(n_ack - a0), 32'(8));
        chk("full_enqs", 32'(n_enq - e0), 32'(8));
        chk("stall_no_deq", 32'(n_deq - d0), 32'(0));
        chk("full_flag_set", 32'(full_out), 32'(1));
        chk("full_count", 32'(count_out), 32'(8));
        chk("full_qlen", 32'(q_len_in), 32'(8));
        chk("full_byte9_held", 32'(des_data_in), 32'h09);

        // Release the consumer and drain everything in order
        des_valid_in = 1'b0; cons_ready_in = 1'b1;
        c0 = n_cons; b = 0;
        while (!((n_cons - c0) >= 9 && !cons_valid_out) && b < 120) begin tick(); b++; end
        chk("drain_bytes", 32'(n_cons - c0), 32'(9));
        chk("drain_count", 32'(count_out), 32'(0));
        chk("drain_sb_empty", 32'(sb.size()), 32'(0));
        chk("drain_len_err", 32'(len_err_out), 32'(0));

        // count = 3 with one byte held at the consumer, then contention
        cons_ready_in = 1'b0;
        des_data_in = 8'h40; stream_end = 8'h40; des_valid_in = 1'b1;
        b = 0;
        while (!cons_valid_out && b < 20) begin tick(); b++; end
        des_data_in = 8'h41; stream_end = 8'h43; des_valid_in = 1'b1;
        b = 0;
        while (count_out != 8'd3 && b < 30) begin tick(); b++; end
        chk("alt_setup_count", 32'(count_out), 32'(3));
        chk("alt_setup_held", 32'(cons_data_out), 32'h40);
        pulse_log.delete();
        des_data_in = 8'h50; stream_end = 8'h7F; des_valid_in = 1'b1; cons_ready_in = 1'b1;
        repeat (40) tick();
        des_valid_in = 1'b0;
        np = pulse_log.size();
        chk("alt_enough_pulses", 32'(np >= 8), 32'(1));
        if (np > 0) chk("alt_first_is_enq", 32'(pulse_log[0]), 32'(1));
        for (int i = 1; i < np; i++) chk("alt_alternate", 32'(pulse_log[i] == pulse_log[i-1]), 32'(0));
        b = 0;
        while (!(empty_out && !cons_valid_out && sb.size() == 0) && b < 120) begin tick(); b++; end
        chk("alt_drain_sb", 32'(sb.size()), 32'(0));
        chk("alt_count_vs_len", 32'(count_out), 32'(q_len_in));
        chk("alt_len_err", 32'(len_err_out), 32'(0));

        // Length mismatch, then reset during ENQ
        cons_ready_in = 1'b0;
        des_data_in = 8'h70; stream_end = 8'h70; des_valid_in = 1'b1;
        b = 0;
        while (!cons_valid_out && b < 20) begin tick(); b++; end
        des_data_in = 8'h71; stream_end = 8'h74; des_valid_in = 1'b1;
        b = 0;
        while (count_out != 8'd4 && b < 30) begin tick(); b++; end
        chk("lerr_setup_count", 32'(count_out), 32'(4));
        chk("lerr_before", 32'(len_err_out), 32'(0));
        len_force = 1'b1;
        tick();
        chk("lerr_set", 32'(len_err_out), 32'(1));
        len_force = 1'b0;
        repeat (5) begin
            tick();
            chk("lerr_sticky", 32'(len_err_out), 32'(1));
        end
        chk("lerr_count_kept", 32'(count_out), 32'(4));
        sb_en = 1'b0;
        des_data_in = 8'h3C; stream_end = 8'h3C; des_valid_in = 1'b1;
        b = 0;
        while (!q_enq_out && b < 10) begin tick(); b++; end
        chk("abort_in_enq", 32'(q_enq_out), 32'(1));
        reset = 1'b1; des_valid_in = 1'b0;
        tick();
        sb.delete();
        chk("abort_ack", 32'(ack_out), 32'(0));
        chk("abort_q_enq", 32'(q_enq_out), 32'(0));
        chk("abort_count", 32'(count_out), 32'(0));
        chk("abort_empty", 32'(empty_out), 32'(1));
        chk("abort_full", 32'(full_out), 32'(0));
        chk("abort_len_err", 32'(len_err_out), 32'(0));
        chk("abort_cons_valid", 32'(cons_valid_out), 32'(0));
        chk("abort_q_data", 32'(q_data_out), 32'(0));
        reset = 1'b0;
        a0 = n_ack;
        repeat (5) tick();
        chk("post_rst_no_ack", 32'(n_ack - a0), 32'(0));
        chk("post_rst_count", 32'(count_out), 32'(0));
        chk("post_rst_len_err", 32'(len_err_out), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
